// File: rtl/kaktovik_scan_driver.sv
// Binary-to-base-20 converter and multiplexed digit scanner feeding kaktovik_decoder instances.
// Optional leading-zero blanking: define KAKTOVIK_LZB_EN.
module kaktovik_scan_driver #(
   parameter int WIDTH    = 16,
   parameter int NDIGITS  = 4,
   parameter int SCAN_DIV = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               busy,
   output logic               ovf,
   output logic [4:0]         dig_value,
   output logic [NDIGITS-1:0] dig_sel,
   output logic               dig_rbi
);

   localparam int KW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int BW = $clog2(WIDTH);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CONV = 1'b1;

   localparam logic [KW-1:0]      K_LAST = KW'(NDIGITS - 1);
   localparam logic [BW-1:0]      B_LAST = BW'(WIDTH - 1);
   localparam logic [PW-1:0]      P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [NDIGITS-1:0] SEL_MS = NDIGITS'(1) << (NDIGITS - 1);

   // Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1;
   // in_ready is high exactly when the FSM is idle, so nothing is ever queued.
   logic [0:0]       state;
   logic [WIDTH-1:0] dividend;
   logic [4:0]       rem;
   logic [BW-1:0]    bitcnt;
   logic [KW-1:0]    k;
   logic [4:0]       shadow [NDIGITS];
   logic [4:0]       disp   [NDIGITS];
   logic             ovf_q;

   logic [5:0]       r;
   logic             q_bit;
   logic [4:0]       rem_n;
   logic [WIDTH-1:0] div_n;
   logic             digit_done;
   logic             conv_done;
   logic             ovf_n;
   logic [4:0]       disp_n [NDIGITS];

   assign in_ready = (state == ST_IDLE);
   assign busy     = (state == ST_CONV);
   assign ovf      = ovf_q;

   // One restoring-division step per cycle; dividend doubles as the quotient shift register.
   always_comb begin
      r          = {rem, dividend[WIDTH-1]};
      q_bit      = (r >= 6'd20);
      rem_n      = q_bit ? 5'(r - 6'd20) : r[4:0];
      div_n      = {dividend[WIDTH-2:0], q_bit};
      digit_done = (bitcnt == B_LAST);
      conv_done  = digit_done && (k == K_LAST);
      ovf_n      = (div_n != '0);
      for (int i = 0; i < NDIGITS; i++) begin
         if (ovf_n)
            disp_n[i] = 5'd30;
         else if (KW'(i) == k)
            disp_n[i] = rem_n;
         else
            disp_n[i] = shadow[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         dividend <= '0;
         rem      <= '0;
         bitcnt   <= '0;
         k        <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < NDIGITS; i++) begin
            shadow[i] <= '0;
            disp[i]   <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  dividend <= in_data;
                  rem      <= '0;
                  bitcnt   <= '0;
                  k        <= '0;
                  state    <= ST_CONV;
               end
            end
            default: begin
               dividend <= div_n;
               if (digit_done) begin
                  shadow[k] <= rem_n;
                  rem       <= '0;
                  bitcnt    <= '0;
                  k         <= k + KW'(1);
                  if (conv_done) begin
                     // Display registers change only here, so the old value stays up all conversion.
                     ovf_q <= ovf_n;
                     for (int i = 0; i < NDIGITS; i++)
                        disp[i] <= disp_n[i];
                     k     <= '0;
                     state <= ST_IDLE;
                  end
               end else begin
                  rem    <= rem_n;
                  bitcnt <= bitcnt + BW'(1);
               end
            end
         endcase
      end
   end

   logic [PW-1:0]      pre;
   logic [KW-1:0]      sel_idx;
   logic               wrap;
   logic [KW-1:0]      idx_n;
   logic [NDIGITS-1:0] sel_n;
   logic               rbi_n;

   always_comb begin
      wrap = (pre == P_LAST);
      if (!wrap)
         idx_n = sel_idx;
      else if (sel_idx == '0)
         idx_n = K_LAST;
      else
         idx_n = sel_idx - KW'(1);
      sel_n        = '0;
      sel_n[idx_n] = 1'b1;
   end

`ifdef KAKTOVIK_LZB_EN
   // live[i]: digit i or something more significant is nonzero; digit 0 always shows.
   logic [NDIGITS-1:0] live;
   always_comb begin : lzb_scan
      logic acc;
      acc  = 1'b0;
      live = '0;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         acc     = acc | (disp[i] != 5'd0);
         live[i] = acc | (i == 0);
      end
   end
   assign rbi_n = live[idx_n];
`else
   assign rbi_n = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre       <= '0;
         sel_idx   <= K_LAST;
         dig_sel   <= SEL_MS;
         dig_value <= '0;
         dig_rbi   <= 1'b1;
      end else begin
         pre       <= wrap ? '0 : pre + PW'(1);
         sel_idx   <= idx_n;
         dig_sel   <= sel_n;
         dig_value <= disp[idx_n];
         dig_rbi   <= rbi_n;
      end
   end

endmodule
